// File: rtl/mfp_ahb_lite_master.sv
// AHB-Lite initiator: converts valid/ready requests into pipelined SINGLE transfers,
// overlapping the address phase of one transfer with the data phase of the previous.
module mfp_ahb_lite_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011,
  parameter bit         ERR_RETRY = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  // Address stage (A) and data stage (D)
  logic        a_valid_q, a_valid_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [1:0]  hsize_q, hsize_d;
  logic [31:0] a_wdata_q, a_wdata_d;
  logic        d_valid_q, d_valid_d;
  logic        d_write_q, d_write_d;
  logic [31:0] hwdata_q, hwdata_d;
  // Discarded-A bookkeeping when errored transfers are not retried
  logic        drop_q, drop_d;
  logic        pend_err_q, pend_err_d;
  // Response register
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  logic req_legal;
  logic cancel;
  logic bus_ready;
  logic idle_all;
  logic accept;
  logic load_a;
  logic illegal_acc;
  logic a_retire;
  logic d_done;
  logic discard;

  assign req_legal = (req_size == 2'd0) ||
                     ((req_size == 2'd1) && !req_addr[0]) ||
                     ((req_size == 2'd2) && (req_addr[1:0] == 2'b00));

  // First ERROR cycle: the slave has not yet released the bus, so a pending A must not be issued.
  assign cancel    = d_valid_q && HRESP && !HREADY;
  assign bus_ready = !a_valid_q || (HREADY && !cancel);
  assign idle_all  = !a_valid_q && !d_valid_q && !drop_q && !pend_err_q;
  assign req_ready = HRESETn && (req_legal ? bus_ready : idle_all);

  assign accept      = req_valid && req_ready;
  assign load_a      = accept && req_legal;
  assign illegal_acc = accept && !req_legal;
  assign a_retire    = a_valid_q && HREADY;
  assign d_done      = d_valid_q && HREADY;
  assign discard     = (ERR_RETRY == 1'b0) && cancel && a_valid_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    a_valid_d   = a_valid_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    hwdata_d    = hwdata_q;
    drop_d      = drop_q;
    pend_err_d  = d_done && drop_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_error_d = 1'b0;

    if (load_a) begin
      a_valid_d = 1'b1;
      haddr_d   = req_addr;
      hwrite_d  = req_write;
      hsize_d   = req_size;
      a_wdata_d = req_wdata;
    end else if (a_retire || discard) begin
      a_valid_d = 1'b0;
    end

    if (a_retire) begin
      d_valid_d = 1'b1;
      d_write_d = hwrite_q;
      hwdata_d  = a_wdata_q;
    end else if (d_done) begin
      d_valid_d = 1'b0;
    end

    if (discard) begin
      drop_d = 1'b1;
    end else if (d_done) begin
      drop_d = 1'b0;
    end

    if (d_done) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = d_write_q ? 32'h0 : HRDATA;
      rsp_error_d = HRESP;
    end else if (pend_err_q || illegal_acc) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    // NOTE: reset is sampled on the clock edge; HRESETn is not in the sensitivity list.
    if (!HRESETn) begin
      a_valid_q   <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      hwdata_q    <= '0;
      drop_q      <= 1'b0;
      pend_err_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      a_valid_q   <= a_valid_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      hwdata_q    <= hwdata_d;
      drop_q      <= drop_d;
      pend_err_q  <= pend_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign HTRANS    = (a_valid_q && !cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = {1'b0, hsize_q};
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Directed bench for mfp_ahb_lite_master: a retrying instance (u_dut) and a
// non-retrying instance (u_dut_nr) share stimulus; the bench plays the AHB slave.
module tb_mfp_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;

  logic [31:0] HADDR, HWDATA, rsp_rdata;
  logic [2:0]  HBURST, HSIZE;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK, HWRITE, req_ready, rsp_valid, rsp_error;

  logic [31:0] haddr_nr, hwdata_nr, rsp_rdata_nr;
  logic [2:0]  hburst_nr, hsize_nr;
  logic [3:0]  hprot_nr;
  logic [1:0]  htrans_nr;
  logic        hmastlock_nr, hwrite_nr, req_ready_nr, rsp_valid_nr, rsp_error_nr;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  mfp_ahb_lite_master #(.HPROT_VAL(4'b0011), .ERR_RETRY(1'b1)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
    .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  mfp_ahb_lite_master #(.HPROT_VAL(4'b0011), .ERR_RETRY(1'b0)) u_dut_nr (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(haddr_nr), .HBURST(hburst_nr), .HMASTLOCK(hmastlock_nr),
    .HPROT(hprot_nr), .HSIZE(hsize_nr), .HTRANS(htrans_nr), .HWRITE(hwrite_nr), .HWDATA(hwdata_nr),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .req_valid(req_valid), .req_ready(req_ready_nr),
    .req_addr(req_addr), .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_nr), .rsp_rdata(rsp_rdata_nr), .rsp_error(rsp_error_nr)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Advance to the next cycle; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic w, input logic [1:0] s, input logic [31:0] d);
    req_valid = v; req_addr = a; req_write = w; req_size = s; req_wdata = d;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    set_req(1'b1, 32'h100, 1'b0, 2'd2, 32'h0);
    tick(); tick(); #1;
    n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    n_vec++; if (HTRANS !== IDLE) begin n_miss++; $display("FAIL rst_htrans: got %b want 00", HTRANS); end
    n_vec++; if ({HADDR, HWDATA} !== 64'h0) begin n_miss++; $display("FAIL rst_addr_wdata: got %h %h want 0 0", HADDR, HWDATA); end
    n_vec++; if ({HWRITE, HSIZE} !== 4'h0) begin n_miss++; $display("FAIL rst_write_size: got %b %h want 0 0", HWRITE, HSIZE); end
    n_vec++; if ({rsp_valid, rsp_error, rsp_rdata} !== 34'h0) begin n_miss++; $display("FAIL rst_rsp: got %b %b %h want 0 0 0", rsp_valid, rsp_error, rsp_rdata); end
    n_vec++; if ({HBURST, HMASTLOCK, HPROT} !== {3'b000, 1'b0, 4'b0011}) begin n_miss++; $display("FAIL rst_consts: got %b %b %b want 000 0 0011", HBURST, HMASTLOCK, HPROT); end
    req_valid = 1'b0;
    HRESETn = 1'b1;
  endtask

  task automatic run_read(input logic [31:0] a, input logic [31:0] d);
    tick(); set_req(1'b1, a, 1'b0, 2'd2, 32'h0); #1;
    n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL rd_ready: got %b want 1", req_ready); end
    n_vec++; if (HTRANS !== IDLE) begin n_miss++; $display("FAIL rd_pre_idle: got %b want 00", HTRANS); end
    tick(); req_valid = 1'b0; #1;
    n_vec++; if (HTRANS !== NONSEQ) begin n_miss++; $display("FAIL rd_nonseq: got %b want 10", HTRANS); end
    n_vec++; if ({HADDR, HWRITE, HSIZE} !== {a, 1'b0, 3'd2}) begin n_miss++; $display("FAIL rd_addr: got %h %b %h want %h 0 2", HADDR, HWRITE, HSIZE, a); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL rd_early_rsp1: got %b want 0", rsp_valid); end
    tick(); HRDATA = d; #1;
    n_vec++; if (HTRANS !== IDLE) begin n_miss++; $display("FAIL rd_one_nonseq: got %b want 00", HTRANS); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL rd_early_rsp2: got %b want 0", rsp_valid); end
    tick(); HRDATA = 32'h0; #1;
    n_vec++; if ({rsp_valid, rsp_error} !== 2'b10) begin n_miss++; $display("FAIL rd_rsp: got v=%b e=%b want v=1 e=0", rsp_valid, rsp_error); end
    n_vec++; if (rsp_rdata !== d) begin n_miss++; $display("FAIL rd_rdata: got %h want %h", rsp_rdata, d); end
    tick(); #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL rd_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_single_read();
    run_read(32'h1F80_0004, 32'hDEAD_BEEF);
  endtask

  task automatic test_back_to_back();
    HRDATA = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      set_req(i < 4, 32'(4 * i), 1'b1, 2'd2, 32'(i + 1));
      #1;
      if (i < 4) begin
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); end
      end
      n_vec++; if (HTRANS !== ((i >= 1 && i <= 4) ? NONSEQ : IDLE)) begin n_miss++; $display("FAIL b2b_htrans[%0d]: got %b", i, HTRANS); end
      if (i >= 1 && i <= 4) begin
        n_vec++; if ({HADDR, HWRITE} !== {32'(4 * (i - 1)), 1'b1}) begin n_miss++; $display("FAIL b2b_addr[%0d]: got %h %b want %h 1", i, HADDR, HWRITE, 4 * (i - 1)); end
      end
      if (i >= 2 && i <= 5) begin
        n_vec++; if (HWDATA !== 32'(i - 1)) begin n_miss++; $display("FAIL b2b_hwdata[%0d]: got %h want %h", i, HWDATA, i - 1); end
      end
      n_vec++; if (rsp_valid !== (i >= 3 && i <= 6)) begin n_miss++; $display("FAIL b2b_rsp_valid[%0d]: got %b", i, rsp_valid); end
      if (i >= 3 && i <= 6) begin
        n_vec++; if ({rsp_error, rsp_rdata} !== 33'h0) begin n_miss++; $display("FAIL b2b_rsp[%0d]: got e=%b d=%h want 0 0", i, rsp_error, rsp_rdata); end
      end
    end
    HRDATA = 32'h0;
  endtask

  task automatic test_wait_states();
    tick(); set_req(1'b1, 32'h10, 1'b1, 2'd2, 32'hAAAA_5555); #1;
    n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL ws_ready0: got %b want 1", req_ready); end
    tick(); set_req(1'b1, 32'h14, 1'b0, 2'd2, 32'h0); #1;
    n_vec++; if ({HTRANS, HADDR, req_ready} !== {NONSEQ, 32'h10, 1'b1}) begin n_miss++; $display("FAIL ws_c1: got %b %h %b want 10 10 1", HTRANS, HADDR, req_ready); end
    for (int c = 2; c < 4; c++) begin
      tick(); set_req(1'b1, 32'h18, 1'b0, 2'd2, 32'h0); HREADY = 1'b0; #1;
      n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL ws_stall_ready[%0d]: got %b want 0", c, req_ready); end
      n_vec++; if ({HTRANS, HADDR, HWRITE} !== {NONSEQ, 32'h14, 1'b0}) begin n_miss++; $display("FAIL ws_stall_addr[%0d]: got %b %h %b want 10 14 0", c, HTRANS, HADDR, HWRITE); end
      n_vec++; if (HWDATA !== 32'hAAAA_5555) begin n_miss++; $display("FAIL ws_stall_wdata[%0d]: got %h want aaaa5555", c, HWDATA); end
      n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL ws_stall_rsp[%0d]: got %b want 0", c, rsp_valid); end
    end
    tick(); HREADY = 1'b1; #1;
    n_vec++; if ({req_ready, HADDR, HWDATA} !== {1'b1, 32'h14, 32'hAAAA_5555}) begin n_miss++; $display("FAIL ws_release: got %b %h %h want 1 14 aaaa5555", req_ready, HADDR, HWDATA); end
    tick(); req_valid = 1'b0; HRDATA = 32'h1414_1414; #1;
    n_vec++; if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 32'h0}) begin n_miss++; $display("FAIL ws_rsp_wr: got %b %b %h want 1 0 0", rsp_valid, rsp_error, rsp_rdata); end
    n_vec++; if ({HTRANS, HADDR} !== {NONSEQ, 32'h18}) begin n_miss++; $display("FAIL ws_addr18: got %b %h want 10 18", HTRANS, HADDR); end
    tick(); HRDATA = 32'h1818_1818; #1;
    n_vec++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h1414_1414}) begin n_miss++; $display("FAIL ws_rsp_rd14: got %b %h want 1 14141414", rsp_valid, rsp_rdata); end
    n_vec++; if (HTRANS !== IDLE) begin n_miss++; $display("FAIL ws_idle: got %b want 00", HTRANS); end
    tick(); HRDATA = 32'h0; #1;
    n_vec++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h1818_1818}) begin n_miss++; $display("FAIL ws_rsp_rd18: got %b %h want 1 18181818", rsp_valid, rsp_rdata); end
    tick(); #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL ws_end: got %b want 0", rsp_valid); end
  endtask

  task automatic test_error();
    tick(); set_req(1'b1, 32'h20, 1'b0, 2'd2, 32'h0); #1;
    n_vec++; if ({req_ready, req_ready_nr} !== 2'b11) begin n_miss++; $display("FAIL err_ready0: got %b%b want 11", req_ready, req_ready_nr); end
    tick(); set_req(1'b1, 32'h24, 1'b1, 2'd2, 32'h55); #1;
    n_vec++; if ({HTRANS, HADDR, req_ready, req_ready_nr} !== {NONSEQ, 32'h20, 2'b11}) begin n_miss++; $display("FAIL err_c1: got %b %h %b%b want 10 20 11", HTRANS, HADDR, req_ready, req_ready_nr); end
    tick(); req_valid = 1'b0; HREADY = 1'b0; HRESP = 1'b1; #1;
    n_vec++; if ({HTRANS, htrans_nr} !== {IDLE, IDLE}) begin n_miss++; $display("FAIL err_cancel: got %b %b want 00 00", HTRANS, htrans_nr); end
    n_vec++; if ({req_ready, req_ready_nr} !== 2'b00) begin n_miss++; $display("FAIL err_cancel_ready: got %b%b want 00", req_ready, req_ready_nr); end
    tick(); HREADY = 1'b1; HRESP = 1'b1; #1;
    n_vec++; if ({HTRANS, HADDR, HWRITE} !== {NONSEQ, 32'h24, 1'b1}) begin n_miss++; $display("FAIL err_reissue: got %b %h %b want 10 24 1", HTRANS, HADDR, HWRITE); end
    n_vec++; if (htrans_nr !== IDLE) begin n_miss++; $display("FAIL err_nr_noissue0: got %b want 00", htrans_nr); end
    tick(); HRESP = 1'b0; #1;
    n_vec++; if ({rsp_valid, rsp_error, rsp_valid_nr, rsp_error_nr} !== 4'b1111) begin n_miss++; $display("FAIL err_rsp_rd: got %b%b %b%b want 11 11", rsp_valid, rsp_error, rsp_valid_nr, rsp_error_nr); end
    n_vec++; if ({HTRANS, HWDATA} !== {IDLE, 32'h55}) begin n_miss++; $display("FAIL err_wdata: got %b %h want 00 55", HTRANS, HWDATA); end
    n_vec++; if (htrans_nr !== IDLE) begin n_miss++; $display("FAIL err_nr_noissue1: got %b want 00", htrans_nr); end
    tick(); #1;
    n_vec++; if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 32'h0}) begin n_miss++; $display("FAIL err_rsp_wr: got %b %b %h want 1 0 0", rsp_valid, rsp_error, rsp_rdata); end
    n_vec++; if ({rsp_valid_nr, rsp_error_nr, rsp_rdata_nr} !== {2'b11, 32'h0}) begin n_miss++; $display("FAIL err_nr_drop_rsp: got %b %b %h want 1 1 0", rsp_valid_nr, rsp_error_nr, rsp_rdata_nr); end
    n_vec++; if (htrans_nr !== IDLE) begin n_miss++; $display("FAIL err_nr_noissue2: got %b want 00", htrans_nr); end
    tick(); #1;
    n_vec++; if ({rsp_valid, rsp_valid_nr, htrans_nr} !== {2'b00, IDLE}) begin n_miss++; $display("FAIL err_end: got %b %b %b want 0 0 00", rsp_valid, rsp_valid_nr, htrans_nr); end
  endtask

  task automatic test_illegal();
    tick(); set_req(1'b1, 32'h2, 1'b0, 2'd2, 32'h0); #1;
    n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL ill_ready: got %b want 1", req_ready); end
    tick(); req_valid = 1'b0; #1;
    n_vec++; if (HTRANS !== IDLE) begin n_miss++; $display("FAIL ill_no_bus: got %b want 00", HTRANS); end
    n_vec++; if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b11, 32'h0}) begin n_miss++; $display("FAIL ill_rsp: got %b %b %h want 1 1 0", rsp_valid, rsp_error, rsp_rdata); end
    tick(); set_req(1'b1, 32'h2, 1'b0, 2'd1, 32'h0); #1;
    n_vec++; if ({rsp_valid, HTRANS, req_ready} !== {1'b0, IDLE, 1'b1}) begin n_miss++; $display("FAIL ill_half_accept: got %b %b %b want 0 00 1", rsp_valid, HTRANS, req_ready); end
    tick(); set_req(1'b1, 32'h40, 1'b0, 2'd3, 32'h0); #1;
    n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL ill_busy_ready: got %b want 0", req_ready); end
    n_vec++; if ({HTRANS, HADDR, HSIZE} !== {NONSEQ, 32'h2, 3'd1}) begin n_miss++; $display("FAIL ill_half_addr: got %b %h %h want 10 2 1", HTRANS, HADDR, HSIZE); end
    tick(); req_valid = 1'b0; HRDATA = 32'h0000_BEEF; #1;
    n_vec++; if ({HTRANS, rsp_valid} !== {IDLE, 1'b0}) begin n_miss++; $display("FAIL ill_half_dphase: got %b %b want 00 0", HTRANS, rsp_valid); end
    tick(); HRDATA = 32'h0; #1;
    n_vec++; if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 32'h0000_BEEF}) begin n_miss++; $display("FAIL ill_half_rsp: got %b %b %h want 1 0 0000beef", rsp_valid, rsp_error, rsp_rdata); end
    tick(); #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL ill_end: got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    tick(); set_req(1'b1, 32'h30, 1'b0, 2'd2, 32'h0); #1;
    tick(); req_valid = 1'b0; #1;
    n_vec++; if (HTRANS !== NONSEQ) begin n_miss++; $display("FAIL rstm_nonseq: got %b want 10", HTRANS); end
    tick(); set_req(1'b1, 32'h34, 1'b0, 2'd2, 32'h0); HREADY = 1'b0; HRESETn = 1'b0; HRDATA = 32'h7777_7777; #1;
    n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL rstm_ready: got %b want 0", req_ready); end
    tick(); req_valid = 1'b0; HRESETn = 1'b1; HREADY = 1'b1; HRDATA = 32'h0; #1;
    n_vec++; if ({HTRANS, HADDR, HWDATA} !== {IDLE, 64'h0}) begin n_miss++; $display("FAIL rstm_bus: got %b %h %h want 00 0 0", HTRANS, HADDR, HWDATA); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL rstm_rsp0: got %b want 0", rsp_valid); end
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      n_vec++; if ({rsp_valid, HTRANS} !== {1'b0, IDLE}) begin n_miss++; $display("FAIL rstm_quiet[%0d]: got %b %b want 0 00", c, rsp_valid, HTRANS); end
    end
    run_read(32'h1F80_0008, 32'hCAFE_0001);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
